vga_frame_monitor: RTL and testbench
====================================

# vga_frame_monitor

TinyQV peripheral that receives the 8-bit VGA pixel bus our video generators drive and measures it. The bus is packed {vsync, hsync, B[1:0], G[1:0], R[1:0]} and arrives on ui_in, or through a loopback from another tile's uo_out. The block recovers horizontal and vertical timing, checksums each frame's pixel data, and tracks lock state. Firmware reads the results through the standard peripheral register bus and can take a per-frame interrupt, which allows self-test of background generators.

## Interface
- POS_POL, default 1: sync polarity. 1 = sync active-high; 0 = active-low.
- clk  in  1: clock, 64 MHz nominal.
- rst_n  in  1: reset, synchronous, active-low.
- vga_in  in  8: {vsync, hsync, B, G, R}. Already synchronized upstream; no extra synchronizer.
- address  in  6: register address.
- data_in  in  32: write data.
- data_write_n  in  2: 11 = no write. Any other value writes; only the bits defined per register are used.
- data_read_n  in  2: unused.
- data_out  out  32: read data, combinational from address.
- data_ready  out  1: constant 1.
- user_interrupt  out  1: irq_pending & CTRL.irq_en.

## Operation
- Sync inputs: hs = vga_in[6] ~^ POS_POL, vs = vga_in[7] ~^ POS_POL (1 = active). rgb = vga_in[5:0].
- hs_d and vs_d are registered copies of hs and vs.
- Edge events:
  - hs_rise = hs & ~hs_d; hs_fall = ~hs & hs_d.
  - vs_rise = vs & ~vs_d; vs_fall = ~vs & vs_d.
- All measurement counters are 16-bit, saturate at 0xFFFF, and are cleared while the state is IDLE.
- Horizontal timing:
  - h_cnt increments every cycle.
  - On hs_rise: H_PERIOD <= h_cnt+1, then h_cnt <= 0.
  - hp_cnt counts cycles with hs=1. On hs_fall: H_PULSE <= hp_cnt, then hp_cnt <= 0.
- Vertical timing:
  - line_cnt increments on hs_rise.
  - On vs_rise: V_LINES <= line_cnt (+1 if hs_rise occurs in the same cycle), then line_cnt <= 0.
  - vp_cnt counts hs_rise events while vs=1. On vs_fall: V_PULSE <= vp_cnt, then vp_cnt <= 0.
- Checksum:
  - cks is 32-bit. cks <= cks + rgb (mod 2^32) on every cycle with hs=0 and vs=0.
  - On vs_rise: FRAME_CKS <= cks, then cks <= 0 (the current cycle's pixel is not added; vs=1 anyway).
- FRAME_CNT is 16-bit. It increments (wrapping) on every vs_rise when the state is not IDLE.
- State machine: IDLE=0, ACQUIRE=1, MEASURE=2, LOCKED=3.
  - IDLE → ACQUIRE when CTRL.en is written to 1.
  - Any state → IDLE when CTRL.en = 0. Counters and cks are cleared; captured registers are held.
  - ACQUIRE → MEASURE on the first vs_rise. The partial frame is discarded; FRAME_CKS is still written.
  - MEASURE → LOCKED on the next vs_rise. H_PERIOD and V_LINES captured at that edge become the reference values.
  - LOCKED → MEASURE, with geom_chg set, when either:
    - an hs_rise captures an H_PERIOD different from the reference, except on lines where vs=1; or
    - a vs_rise captures a V_LINES different from the reference.
- Interrupt: irq_pending is set on vs_rise only when the state is LOCKED both before and after that edge.
- Registers (byte address):
  - 0x00 CTRL: [0] en, [1] irq_en. R/W.
  - 0x04 STATUS: [1:0] state, [2] irq_pending, [3] geom_chg. Write 1 to bit 2 or bit 3 clears that bit.
  - 0x08: {H_PULSE, H_PERIOD}.
  - 0x0C: {V_PULSE, V_LINES}.
  - 0x10: FRAME_CKS.
  - 0x14: {16'b0, FRAME_CNT}.
  - All other addresses read 0; writes to them are ignored.

## Timing
- Reset: all of the following are 0, and user_interrupt=0.
  - CTRL, state, irq_pending, geom_chg.
  - H_PERIOD, H_PULSE, V_LINES, V_PULSE, FRAME_CKS, FRAME_CNT.
  - All counters, hs_d and vs_d.
- An edge event is acted on at the clock edge where the new sync level is first sampled. Captured registers are readable on data_out in the following cycle.
- user_interrupt rises one cycle after the vs_rise sample. Reads are zero-latency.
- If a set event and a write-1-clear hit in the same cycle, set wins.
- hs_rise and vs_rise in the same cycle: line capture uses the included count, as defined under Vertical timing.
- Reset asserted mid-frame returns the block to IDLE next cycle. A frame that is interrupted never produces an interrupt.
- A CTRL write of en=1 while already enabled leaves the state unchanged.

## Test plan
- Timing measurement: POS_POL=1, en=1; drive 3 frames with:
  - hsync period 100 clocks, hsync pulse 10;
  - 20 lines per frame, vsync 2 lines;
  - vs_rise aligned with hs_rise.
  - Required: H_PERIOD=100, H_PULSE=10, V_LINES=20, V_PULSE=2; state=3 after the 2nd vs_rise; FRAME_CNT=3.
- Checksum: same geometry, rgb=0x3F on all sync-inactive cycles → FRAME_CKS=0x00018EAC (90×18×63).
- Interrupt: with irq_en=1, user_interrupt asserts 1 cycle after the 3rd vs_rise. Write 0x04 with data 0x4 → it deasserts the next cycle.
- Geometry change: after lock, change the H period to 101 → state=2 and geom_chg=1. Relock after 1 full frame at the new period.
- Negative polarity: POS_POL=0 with inverted stimulus gives values identical to the timing-measurement scenario.
- Reset and disable: assert rst_n=0 mid-frame → all registers read 0. Write en=0 while locked → state=0 and captured values are held.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// Purpose: measures sync timing, checksums pixel data and tracks lock state of an 8-bit VGA pixel bus.
// Latency: edge events are captured on the sampling clock edge; results and irq are visible one cycle later.
// Backpressure: none; data_ready is tied high and the video input is never stalled.
module vga_frame_monitor #(
  parameter logic POS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  // Saturating 16-bit increment shared by all measurement counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Decoded sync levels (1 = active regardless of polarity) and pixel data.
  logic       hs;
  logic       vs;
  logic [5:0] rgb;
  logic       hs_rise;
  logic       hs_fall;
  logic       vs_rise;
  logic       vs_fall;

  // Register bus decode.
  logic wr;
  logic wr_ctrl;
  logic wr_stat;

  // Flops and their next-state values.
  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_pend_q, irq_pend_d;
  logic        geom_chg_q, geom_chg_d;
  logic        hs_d_q, hs_d_d;
  logic        vs_d_q, vs_d_d;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] hp_cnt_q, hp_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [15:0] vp_cnt_q, vp_cnt_d;
  logic [31:0] cks_q, cks_d;
  logic [15:0] h_period_q, h_period_d;
  logic [15:0] h_pulse_q, h_pulse_d;
  logic [15:0] v_lines_q, v_lines_d;
  logic [15:0] v_pulse_q, v_pulse_d;
  logic [31:0] frame_cks_q, frame_cks_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] ref_h_q, ref_h_d;
  logic [15:0] ref_v_q, ref_v_d;

  logic active;
  logic geom_hit;
  logic geom_set;
  logic irq_set;

  // Read strobes carry no meaning here and upper write-data bits are unused.
  logic unused;
  assign unused = ^{data_read_n, data_in[31:4]};

  assign hs      = vga_in[6] ~^ POS_POL;
  assign vs      = vga_in[7] ~^ POS_POL;
  assign rgb     = vga_in[5:0];
  assign hs_rise = hs & ~hs_d_q;
  assign hs_fall = ~hs & hs_d_q;
  assign vs_rise = vs & ~vs_d_q;
  assign vs_fall = ~vs & vs_d_q;

  assign wr      = (data_write_n != 2'b11);
  assign wr_ctrl = wr && (address == 6'h00);
  assign wr_stat = wr && (address == 6'h04);

  assign active     = (state_q != IDLE);
  assign data_ready = 1'b1;
  assign user_interrupt = irq_pend_q & irq_en_q;

  // Next-state logic: timing counters, captures, checksum, lock FSM and status bits.
  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    irq_en_d    = irq_en_q;
    irq_pend_d  = irq_pend_q;
    geom_chg_d  = geom_chg_q;
    hs_d_d      = hs;
    vs_d_d      = vs;
    h_cnt_d     = sat_inc(h_cnt_q);
    hp_cnt_d    = hp_cnt_q;
    line_cnt_d  = line_cnt_q;
    vp_cnt_d    = vp_cnt_q;
    cks_d       = cks_q;
    h_period_d  = h_period_q;
    h_pulse_d   = h_pulse_q;
    v_lines_d   = v_lines_q;
    v_pulse_d   = v_pulse_q;
    frame_cks_d = frame_cks_q;
    frame_cnt_d = frame_cnt_q;
    ref_h_d     = ref_h_q;
    ref_v_d     = ref_v_q;
    geom_set    = 1'b0;
    irq_set     = 1'b0;

    if (wr_ctrl) begin
      en_d     = data_in[0];
      irq_en_d = data_in[1];
    end

    // Horizontal period: capture count-including-this-cycle at each hsync start.
    if (hs_rise) begin
      if (active) h_period_d = sat_inc(h_cnt_q);
      h_cnt_d = 16'd0;
    end

    // Horizontal pulse width.
    if (hs_fall) begin
      if (active) h_pulse_d = hp_cnt_q;
      hp_cnt_d = 16'd0;
    end else if (hs) begin
      hp_cnt_d = sat_inc(hp_cnt_q);
    end

    // Lines per frame; a coincident hsync start belongs to the closing frame.
    if (hs_rise) line_cnt_d = sat_inc(line_cnt_q);
    if (vs_rise) begin
      if (active) v_lines_d = hs_rise ? sat_inc(line_cnt_q) : line_cnt_q;
      line_cnt_d = 16'd0;
    end

    // Vertical pulse width in lines.
    if (vs_fall) begin
      if (active) v_pulse_d = vp_cnt_q;
      vp_cnt_d = 16'd0;
    end else if (vs && hs_rise) begin
      vp_cnt_d = sat_inc(vp_cnt_q);
    end

    // Pixel checksum over sync-inactive cycles only.
    if (vs_rise) begin
      if (active) begin
        frame_cks_d = cks_q;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      cks_d = 32'd0;
    end else if (!hs && !vs) begin
      cks_d = cks_q + {26'd0, rgb};
    end

    // While idle nothing accumulates.
    if (!active) begin
      h_cnt_d    = 16'd0;
      hp_cnt_d   = 16'd0;
      line_cnt_d = 16'd0;
      vp_cnt_d   = 16'd0;
      cks_d      = 32'd0;
    end

    // Lines inside vsync are excluded from the period check: real sources often
    // stretch or realign the first line of a frame.
    geom_hit = (hs_rise && !vs && (h_period_d != ref_h_q)) ||
               (vs_rise && (v_lines_d != ref_v_q));

    case (state_q)
      IDLE:    state_d = ACQUIRE;
      ACQUIRE: if (vs_rise) state_d = MEASURE;
      MEASURE: begin
        if (vs_rise) begin
          state_d = LOCKED;
          ref_h_d = h_period_d;
          ref_v_d = v_lines_d;
        end
      end
      LOCKED: begin
        if (geom_hit) begin
          state_d  = MEASURE;
          geom_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en_d) begin
      state_d  = IDLE;
      geom_set = 1'b0;
    end

    irq_set = vs_rise && (state_q == LOCKED) && (state_d == LOCKED);

    // Status bits: write-1 clears, a simultaneous set wins.
    if (wr_stat && data_in[2]) irq_pend_d = 1'b0;
    if (wr_stat && data_in[3]) geom_chg_d = 1'b0;
    if (irq_set)  irq_pend_d = 1'b1;
    if (geom_set) geom_chg_d = 1'b1;
  end

  // Register read mux, combinational from address.
  always_comb begin
    data_out = 32'd0;
    case (address)
      6'h00:   data_out = {30'd0, irq_en_q, en_q};
      6'h04:   data_out = {28'd0, geom_chg_q, irq_pend_q, state_q};
      6'h08:   data_out = {h_pulse_q, h_period_q};
      6'h0C:   data_out = {v_pulse_q, v_lines_q};
      6'h10:   data_out = frame_cks_q;
      6'h14:   data_out = {16'd0, frame_cnt_q};
      default: data_out = 32'd0;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_pend_q  <= 1'b0;
      geom_chg_q  <= 1'b0;
      hs_d_q      <= 1'b0;
      vs_d_q      <= 1'b0;
      h_cnt_q     <= 16'd0;
      hp_cnt_q    <= 16'd0;
      line_cnt_q  <= 16'd0;
      vp_cnt_q    <= 16'd0;
      cks_q       <= 32'd0;
      h_period_q  <= 16'd0;
      h_pulse_q   <= 16'd0;
      v_lines_q   <= 16'd0;
      v_pulse_q   <= 16'd0;
      frame_cks_q <= 32'd0;
      frame_cnt_q <= 16'd0;
      ref_h_q     <= 16'd0;
      ref_v_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      irq_pend_q  <= irq_pend_d;
      geom_chg_q  <= geom_chg_d;
      hs_d_q      <= hs_d_d;
      vs_d_q      <= vs_d_d;
      h_cnt_q     <= h_cnt_d;
      hp_cnt_q    <= hp_cnt_d;
      line_cnt_q  <= line_cnt_d;
      vp_cnt_q    <= vp_cnt_d;
      cks_q       <= cks_d;
      h_period_q  <= h_period_d;
      h_pulse_q   <= h_pulse_d;
      v_lines_q   <= v_lines_d;
      v_pulse_q   <= v_pulse_d;
      frame_cks_q <= frame_cks_d;
      frame_cnt_q <= frame_cnt_d;
      ref_h_q     <= ref_h_d;
      ref_v_q     <= ref_v_d;
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Purpose: directed bench for vga_frame_monitor, positive and negative sync polarity side by side.
// Latency: register reads sampled 1 ns after address change; irq sampled on falling clock edges.
// Backpressure: none; the bench drives one pixel per clock continuously within a frame.
`timescale 1ns/1ps
module tb_vga_frame_monitor;

  logic        clk;
  logic        rst_n;
  logic [7:0]  vga_p;
  logic [7:0]  vga_n;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] dout_p;
  logic [31:0] dout_n;
  logic        rdy_p;
  logic        rdy_n;
  logic        ui_p;
  logic        ui_n;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  vga_frame_monitor #(.POS_POL(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_p), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(dout_p),
    .data_ready(rdy_p), .user_interrupt(ui_p)
  );

  vga_frame_monitor #(.POS_POL(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_n), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(dout_n),
    .data_ready(rdy_n), .user_interrupt(ui_n)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value goes into the scoreboard as the address is driven,
  // and is popped when the data bus is sampled.
  task automatic rd(input logic [5:0] a, input logic [31:0] e, input string tag);
    logic [31:0] ev;
    string       tv;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    address = a;
    #1;
    ev = exp_q.pop_front();
    tv = tag_q.pop_front();
    chk({tv, "_pos"}, dout_p, ev);
    chk({tv, "_neg"}, dout_n, ev);
  endtask

  task automatic wr_reg(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    address      = a;
    data_in      = d;
    data_write_n = 2'b00;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic set_vga(input logic hs, input logic vs, input logic [5:0] rgb);
    vga_p = {vs, hs, rgb};
    vga_n = {~vs, ~hs, rgb};
  endtask

  // One frame: 20 lines of per clocks, hsync 10 clocks, vsync 2 lines, both
  // starting together. Stops early at stop_line. Samples irq around the frame start
  // and optionally writes 1 to STATUS[2] right after the vsync edge.
  task automatic drive_frame(input int per, input int stop_line, input bit do_clr,
                             output logic [1:0] irq0, output logic [1:0] irq1,
                             output logic [1:0] irq2);
    irq0 = 2'b00;
    irq1 = 2'b00;
    irq2 = 2'b00;
    for (int l = 0; l < 20; l++) begin
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        if (l == stop_line) return;
        if (l == 0 && c == 0) irq0 = {ui_p, ui_n};
        if (l == 0 && c == 1) begin
          irq1 = {ui_p, ui_n};
          if (do_clr) begin
            address      = 6'h04;
            data_in      = 32'h4;
            data_write_n = 2'b00;
          end
        end
        if (l == 0 && c == 2) begin
          irq2 = {ui_p, ui_n};
          data_write_n = 2'b11;
        end
        set_vga(c < 10, l < 2, 6'h3F);
      end
    end
  endtask

  task automatic rd_all_zero(input string tag);
    rd(6'h00, 32'h0, {tag, "_ctrl"});
    rd(6'h04, 32'h0, {tag, "_status"});
    rd(6'h08, 32'h0, {tag, "_htime"});
    rd(6'h0C, 32'h0, {tag, "_vtime"});
    rd(6'h10, 32'h0, {tag, "_cks"});
    rd(6'h14, 32'h0, {tag, "_fcnt"});
    chk({tag, "_irq"}, {30'd0, ui_p, ui_n}, 32'h0);
  endtask

  initial begin
    logic [1:0] i0, i1, i2;
    rst_n        = 1'b0;
    address      = 6'h00;
    data_in      = 32'h0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    set_vga(1'b0, 1'b0, 6'h00);

    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd_all_zero("reset");
    chk("data_ready", {30'd0, rdy_p, rdy_n}, 32'h3);

    // Enable with interrupts; state goes to ACQUIRE.
    wr_reg(6'h00, 32'h3);
    rd(6'h00, 32'h3, "ctrl_en");
    rd(6'h04, 32'h1, "st_acquire");
    repeat (5) @(negedge clk);

    // Frame 1: ACQUIRE -> MEASURE, no interrupt.
    drive_frame(100, 99, 1'b0, i0, i1, i2);
    chk("irq_f1", {30'd0, i1}, 32'h0);
    rd(6'h04, 32'h2, "st_measure");

    // Frame 2: MEASURE -> LOCKED, first full-frame measurements.
    drive_frame(100, 99, 1'b0, i0, i1, i2);
    chk("irq_f2", {30'd0, i1}, 32'h0);
    rd(6'h04, 32'h3, "st_locked");
    rd(6'h08, 32'h000A0064, "htime_100");
    rd(6'h0C, 32'h00020014, "vtime_20");
    rd(6'h10, 32'h00018EAC, "cks_f1");
    rd(6'h14, 32'h2, "fcnt_2");

    // Frame 3: locked across the edge -> interrupt, then write-1-clear.
    drive_frame(100, 99, 1'b1, i0, i1, i2);
    chk("irq_before_edge", {30'd0, i0}, 32'h0);
    chk("irq_after_edge", {30'd0, i1}, 32'h3);
    chk("irq_after_clear", {30'd0, i2}, 32'h0);
    rd(6'h04, 32'h3, "st_cleared");
    rd(6'h10, 32'h00018EAC, "cks_f2");
    rd(6'h14, 32'h3, "fcnt_3");

    // Frame 4 at period 101: irq at its edge, then geometry change drops lock.
    drive_frame(101, 99, 1'b0, i0, i1, i2);
    chk("irq_f4", {30'd0, i1}, 32'h3);
    rd(6'h04, 32'hE, "st_geomchg");
    rd(6'h08, 32'h000A0065, "htime_101");

    // Frame 5 at period 101: relocks on its edge and stays locked.
    drive_frame(101, 99, 1'b0, i0, i1, i2);
    chk("irq_f5_relock", {30'd0, i1}, 32'h3);
    rd(6'h04, 32'hF, "st_relocked");
    rd(6'h0C, 32'h00020014, "vtime_f4");
    rd(6'h10, 32'h0001931A, "cks_f4");
    rd(6'h14, 32'h5, "fcnt_5");

    // Re-writing en=1 while locked leaves the state alone; unmapped space is inert.
    wr_reg(6'h00, 32'h3);
    rd(6'h04, 32'hF, "st_reenable");
    wr_reg(6'h20, 32'hFFFF_FFFF);
    rd(6'h20, 32'h0, "unmapped");
    rd(6'h00, 32'h3, "ctrl_kept");

    // Disable while locked: IDLE, captures held.
    wr_reg(6'h00, 32'h0);
    rd(6'h04, 32'hC, "st_disabled");
    rd(6'h00, 32'h0, "ctrl_off");
    rd(6'h08, 32'h000A0065, "htime_held");
    rd(6'h10, 32'h0001931A, "cks_held");
    rd(6'h14, 32'h5, "fcnt_held");
    chk("irq_disabled", {30'd0, ui_p, ui_n}, 32'h0);

    // Re-enable, run part of a frame, then reset mid-frame.
    wr_reg(6'h00, 32'h3);
    rd(6'h04, 32'hD, "st_acq2");
    drive_frame(100, 5, 1'b0, i0, i1, i2);
    rd(6'h04, 32'hE, "st_midframe");
    rst_n = 1'b0;
    @(negedge clk);
    rd_all_zero("midreset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(6'h04, 32'h0, "st_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
